// File: rtl/irq_ctrl_if.sv
// Register-window bus between a requester and irq_ctrl.
// Signal names keep the block's port naming: _i into the slave, _o out of it.
interface irq_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller with claim/complete handshake.
// Owns ENABLE/PENDING registers and drives one registered irq_o.
module irq_ctrl #(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h7000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] src_i,
  irq_ctrl_if.slave          bus,
  output logic               irq_o
);

  localparam int unsigned IDW = 5;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT     = 2'd1,
    IN_SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, edge_q;
  logic [1:0]         warm_q;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [IDW-1:0]     act_q, act_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ack_q;
  logic               irq_q, irq_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] masked;
  logic [NUM_SRC-1:0] claim_mask;
  logic [IDW-1:0]     claim_id;
  logic               hit;
  logic [1:0]         off;
  logic               claim;
  logic               complete;
  logic               unused_bits;

  // Edges are suppressed until the edge flop holds a post-reset sample,
  // so a line held high through reset does not look like a new edge.
  assign rise   = sync2_q & ~edge_q & {NUM_SRC{warm_q == 2'd3}};
  assign masked = pend_q & en_q;

  assign hit = bus.req_i && (bus.addr_i[31:4] == BASE_ADDR[31:4]);
  assign off = bus.addr_i[3:2];

  assign claim    = hit && !bus.we_i && (off == 2'd1) &&
                    (state_q == ASSERT) && (|masked);
  assign complete = hit && bus.we_i && (off == 2'd3) &&
                    (state_q == IN_SERVICE) && (bus.wdata_i[IDW-1:0] == act_q);

  assign unused_bits = ^{bus.addr_i[1:0], bus.wdata_i};

  // Lowest-index enabled pending source wins.
  always_comb begin
    claim_id   = '0;
    claim_mask = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (masked[i]) begin
        claim_id      = IDW'(i + 1);
        claim_mask    = '0;
        claim_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    pend_d  = pend_q | rise;
    act_d   = act_q;
    rdata_d = '0;

    if (hit && bus.we_i && (off == 2'd0)) begin
      en_d = bus.wdata_i[NUM_SRC-1:0];
    end

    if (hit && !bus.we_i) begin
      case (off)
        2'd0:    rdata_d = 32'(en_q);
        2'd1:    if (claim) rdata_d = 32'(claim_id);
        2'd2:    rdata_d = 32'(pend_q);
        default: rdata_d = '0;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (|masked) state_d = ASSERT;
      end
      ASSERT: begin
        if (claim) begin
          state_d = IN_SERVICE;
          act_d   = claim_id;
          // A new edge on the claimed bit in the same cycle keeps it pending.
          pend_d  = (pend_q & ~claim_mask) | rise;
        end else if (!(|masked)) begin
          state_d = IDLE;
        end
      end
      IN_SERVICE: begin
        if (complete) begin
          state_d = IDLE;
          act_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    irq_d = (state_d == ASSERT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
      warm_q  <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= src_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      warm_q  <= (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
      en_q    <= en_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      rdata_q <= rdata_d;
      ack_q   <= hit;
      irq_q   <= irq_d;
    end
  end

  assign bus.rdata_o = rdata_q;
  assign bus.ack_o   = ack_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a behavioural model.
module tb_irq_ctrl;

  localparam int unsigned NS   = 8;
  localparam logic [31:0] BASE = 32'h7000_0000;
  localparam logic [31:0] A_EN = BASE + 32'h0;
  localparam logic [31:0] A_SRC = BASE + 32'h4;
  localparam logic [31:0] A_PND = BASE + 32'h8;
  localparam logic [31:0] A_CMP = BASE + 32'hC;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] src;
  logic          irq;

  always #5 clk = ~clk;

  irq_ctrl_if bus_if ();

  irq_ctrl #(.NUM_SRC(NS), .BASE_ADDR(BASE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .src_i (src),
    .bus   (bus_if),
    .irq_o (irq)
  );

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = no request, 1 = requesting, 2 = one source in service.
  logic [NS-1:0] m_en = '0, m_pend = '0;
  int            m_mode = 0;
  logic [4:0]    m_act = '0;
  logic [31:0]   m_rdata = '0;
  logic          m_ack = 1'b0, m_irq = 1'b0;
  logic [NS-1:0] smp[$];

  always @(posedge clk) begin : model
    logic [NS-1:0] rise, masked, npend, nen;
    logic          hit;
    logic [1:0]    off;
    int            id, nmode;
    if (rst) begin
      m_en = '0; m_pend = '0; m_mode = 0; m_act = '0;
      m_rdata = '0; m_ack = 1'b0; m_irq = 1'b0;
      smp.delete();
    end else begin
      // Edge at this clock: line sampled high two clocks ago, low three clocks ago,
      // and both samples taken after reset.
      smp.push_back(src);
      if (smp.size() > 4) void'(smp.pop_front());
      rise = (smp.size() >= 4) ? (smp[1] & ~smp[0]) : '0;

      hit    = bus_if.req_i && ((bus_if.addr_i >> 4) == (BASE >> 4));
      off    = bus_if.addr_i[3:2];
      masked = m_pend & m_en;
      id = 0;
      for (int i = 0; i < int'(NS); i++) if (id == 0 && masked[i]) id = i + 1;

      m_ack   = hit;
      m_rdata = '0;
      nmode   = m_mode;
      npend   = m_pend | rise;
      nen     = m_en;

      if (hit && bus_if.we_i && off == 2'd0) nen = bus_if.wdata_i[NS-1:0];
      if (hit && !bus_if.we_i) begin
        if (off == 2'd0) m_rdata = 32'(m_en);
        else if (off == 2'd2) m_rdata = 32'(m_pend);
        else if (off == 2'd1 && m_mode == 1 && id != 0) begin
          m_rdata = 32'(id);
          nmode = 2;
          m_act = 5'(id);
          npend[id-1] = rise[id-1];
        end
      end

      if (m_mode == 0 && masked != '0) nmode = 1;
      else if (m_mode == 1 && nmode == 1 && masked == '0) nmode = 0;
      else if (m_mode == 2 && hit && bus_if.we_i && off == 2'd3 &&
               bus_if.wdata_i[4:0] == m_act) begin
        nmode = 0;
        m_act = '0;
      end

      m_mode = nmode;
      m_en   = nen;
      m_pend = npend;
      m_irq  = (nmode == 1);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_ack", 32'(bus_if.ack_o), 32'(m_ack));
      chk("cyc_rdata", bus_if.rdata_o, m_rdata);
      chk("cyc_irq", 32'(irq), 32'(m_irq));
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic ack);
    bus_if.req_i   = 1'b1;
    bus_if.we_i    = we;
    bus_if.addr_i  = addr;
    bus_if.wdata_i = wd;
    cyc(1);
    rd  = bus_if.rdata_o;
    ack = bus_if.ack_o;
    bus_if.req_i = 1'b0;
    bus_if.we_i  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    logic        ack;
    access(1'b1, addr, wd, rd, ack);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr,
                        input logic [31:0] exp_d, input logic exp_ack);
    logic [31:0] rd;
    logic        ack;
    access(1'b0, addr, 32'h0, rd, ack);
    chk({name, "_ack"}, 32'(ack), 32'(exp_ack));
    chk(name, rd, exp_d);
  endtask

  task automatic pulse(input logic [NS-1:0] m);
    src = m;
    cyc(1);
    src = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic        a;
    int          r;
    rst = 1'b1;
    src = '0;
    bus_if.req_i = 1'b0; bus_if.we_i = 1'b0;
    bus_if.addr_i = '0;  bus_if.wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;

    // Access during reset cycle gets no acknowledge.
    access(1'b0, A_PND, 32'h0, d, a);
    chk("reset_cycle_ack", 32'(a), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    cyc(4);
    rd_chk("reset_enable", A_EN, 32'h0, 1'b1);
    rd_chk("reset_pending", A_PND, 32'h0, 1'b1);

    // Single source latency and claim.
    wr(A_EN, 32'h05);
    src = 8'h04;
    cyc(1);
    src = '0;
    cyc(2);
    chk("lat_irq_e3", 32'(irq), 32'h0);
    cyc(1);
    chk("lat_irq_e4", 32'(irq), 32'h1);
    rd_chk("pend_04", A_PND, 32'h04, 1'b1);
    rd_chk("claim_3", A_SRC, 32'h3, 1'b1);
    chk("irq_after_claim", 32'(irq), 32'h0);
    rd_chk("pend_after_claim", A_PND, 32'h0, 1'b1);
    wr(A_CMP, 32'h3);

    // Two simultaneous sources resolve by priority.
    wr(A_EN, 32'hFF);
    pulse(8'h42);
    cyc(5);
    rd_chk("claim_2", A_SRC, 32'h2, 1'b1);
    wr(A_CMP, 32'h2);
    cyc(1);
    chk("irq_reassert", 32'(irq), 32'h1);
    rd_chk("claim_7", A_SRC, 32'h7, 1'b1);
    wr(A_CMP, 32'h7);
    cyc(2);
    chk("irq_quiet", 32'(irq), 32'h0);

    // Mismatching complete is ignored; edges accumulate while in service.
    pulse(8'h04);
    cyc(5);
    rd_chk("claim_3b", A_SRC, 32'h3, 1'b1);
    pulse(8'h01);
    wr(A_CMP, 32'h5);
    cyc(5);
    chk("irq_in_service", 32'(irq), 32'h0);
    rd_chk("claim_in_service", A_SRC, 32'h0, 1'b1);
    rd_chk("pend_accum", A_PND, 32'h01, 1'b1);
    wr(A_CMP, 32'h3);
    cyc(1);
    chk("irq_after_complete", 32'(irq), 32'h1);
    rd_chk("claim_1", A_SRC, 32'h1, 1'b1);
    wr(A_CMP, 32'h1);

    // Disabled source latches but does not interrupt until enabled.
    wr(A_EN, 32'h00);
    pulse(8'h01);
    cyc(5);
    rd_chk("pend_disabled", A_PND, 32'h01, 1'b1);
    chk("irq_disabled", 32'(irq), 32'h0);
    wr(A_EN, 32'h01);
    cyc(1);
    chk("irq_enabled", 32'(irq), 32'h1);
    rd_chk("claim_1b", A_SRC, 32'h1, 1'b1);
    wr(A_CMP, 32'h1);

    // Out-of-window and no-effect accesses.
    rd_chk("oow_read", BASE + 32'h10, 32'h0, 1'b0);
    wr(BASE + 32'h10, 32'hAA);
    rd_chk("enable_kept", A_EN, 32'h01, 1'b1);
    rd_chk("claim_idle", A_SRC, 32'h0, 1'b1);
    rd_chk("read_complete", A_CMP, 32'h0, 1'b1);
    wr(A_PND, 32'hFF);
    rd_chk("pend_ro", A_PND, 32'h0, 1'b1);

    // Reset mid-service with a line held high through reset.
    wr(A_EN, 32'hFF);
    pulse(8'h04);
    cyc(5);
    rd_chk("claim_3c", A_SRC, 32'h3, 1'b1);
    src = 8'h10;
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_irq", 32'(irq), 32'h0);
    rd_chk("rst_enable", A_EN, 32'h0, 1'b1);
    rd_chk("rst_pending", A_PND, 32'h0, 1'b1);
    wr(A_EN, 32'hFF);
    cyc(8);
    chk("rst_held_irq", 32'(irq), 32'h0);
    rd_chk("rst_held_pend", A_PND, 32'h0, 1'b1);
    rd_chk("rst_claim", A_SRC, 32'h0, 1'b1);
    src = '0;
    cyc(4);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      src = src ^ NS'($urandom & $urandom & $urandom);
      bus_if.req_i = ($urandom_range(0, 2) == 0);
      bus_if.we_i  = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 9);
      if (r < 8) bus_if.addr_i = BASE + 32'(4 * $urandom_range(0, 3)) +
                                 (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0);
      else if (r == 8) bus_if.addr_i = BASE + 32'h10 + 32'(4 * $urandom_range(0, 3));
      else bus_if.addr_i = $urandom;
      r = $urandom_range(0, 2);
      if (r == 0) bus_if.wdata_i = 32'(m_act);
      else if (r == 1) bus_if.wdata_i = 32'($urandom_range(0, 9));
      else bus_if.wdata_i = $urandom;
      cyc(1);
    end
    rst = 1'b0;
    bus_if.req_i = 1'b0;
    bus_if.we_i  = 1'b0;
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8, number of external interrupt sources (1..31).
REQ-002 Parameter BASE_ADDR, default 32'h7000_0000, word-aligned base address of the register window.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 src_i  input  NUM_SRC  asynchronous device interrupt lines, rising-edge sensitive.
REQ-007 req_i  input  1  bus request, one-cycle pulse per access.
REQ-008 we_i  input  1  write enable, qualified by req_i.
REQ-009 addr_i  input  32  byte address, qualified by req_i.
REQ-010 wdata_i  input  32  write data.
REQ-011 rdata_o  output  32  read data, valid only while ack_o=1.
REQ-012 ack_o  output  1  access acknowledge.
REQ-013 irq_o  output  1  registered request to the CSR block's irq_i input.

Function
REQ-014 Register map (offset from BASE_ADDR): 0x0 ENABLE (RW, bits NUM_SRC-1:0); 0x4 SOURCE (RO, claim); 0x8 PENDING (RO); 0xC COMPLETE (WO).
REQ-015 A request is decoded only when addr_i[31:4]==BASE_ADDR[31:4]; other addresses produce no ack_o and no state change.
REQ-016 In-window accesses: ack_o=1 exactly one cycle after req_i; rdata_o registered, driven only with ack_o, otherwise 0.
REQ-017 In-window unmapped bits, writes to RO registers, and reads of COMPLETE: rdata_o=0 with ack_o, no state change.
REQ-018 Each src_i bit passes a 2-flop synchronizer and a third flop for edge detection; a 0->1 transition sets PENDING[n].
REQ-019 Latency: src_i first sampled high at edge 1 -> PENDING[n] set at edge 3 -> irq_o high at edge 4 (when enabled and IDLE).
REQ-020 Source ID = bit index + 1; ID 0 means "none"; the lowest index has the highest priority.
REQ-021 FSM states IDLE, ASSERT, IN_SERVICE; the state is not software-visible.
REQ-022 IDLE -> ASSERT when (PENDING & ENABLE)!=0; irq_o=1 on entering ASSERT.
REQ-023 ASSERT -> IDLE when (PENDING & ENABLE) becomes 0 with no claim; irq_o deasserts on the same edge.
REQ-024 Read of SOURCE in ASSERT returns the highest-priority enabled pending ID in rdata_o[4:0].
REQ-025 That read clears its PENDING bit, latches it as active_id, and moves ASSERT -> IN_SERVICE with irq_o=0 on that edge.
REQ-026 Read of SOURCE in IDLE or IN_SERVICE returns 0 and changes nothing.
REQ-027 Write of COMPLETE with wdata_i[4:0]==active_id in IN_SERVICE -> IDLE, clears active_id to 0; a mismatching ID or any other state is ignored.
REQ-028 Edges keep accumulating in PENDING during IN_SERVICE; irq_o stays 0 until return to IDLE.
REQ-029 Simultaneous edge and claim on the same bit: the set wins and PENDING[n] remains 1.
REQ-030 Disabled sources still latch PENDING but never drive irq_o or get claimed; enabling one later asserts irq_o per REQ-022.
REQ-031 Only one source is in service at a time; there is no nesting or preemption.

Reset
REQ-032 When rst_i=1 at a clock edge, the block SHALL clear ENABLE, PENDING, active_id, the synchronizer and edge flops, rdata_o, ack_o and irq_o to 0, and force state to IDLE.
REQ-033 Reset mid-service SHALL abandon the active claim; a src_i held high through reset produces no edge after reset is released.
REQ-034 An access requested in the reset cycle SHALL receive no ack_o.

Verification
REQ-035 Write ENABLE=0x05, pulse src_i[2] -> PENDING reads 0x04, irq_o rises 4 edges after sampling, SOURCE reads 3, irq_o=0 next cycle.
REQ-036 src_i[1] and src_i[6] rise together with ENABLE=0xFF -> first claim returns 2, COMPLETE(2), irq_o reasserts, second claim returns 7.
REQ-037 In IN_SERVICE(ID 3), write COMPLETE=5 -> no change and irq_o stays 0; COMPLETE=3 -> IDLE.
REQ-038 ENABLE=0x00, pulse src_i[0] -> PENDING=0x01, irq_o=0; write ENABLE=0x01 -> irq_o=1.
REQ-039 Access at BASE_ADDR+0x10 -> no ack_o; read of SOURCE in IDLE -> rdata_o=0, ack_o=1.
REQ-040 Assert rst_i during IN_SERVICE -> all registers read 0, irq_o=0, and a subsequent claim returns 0.
